// File: rtl/data_mem_arbiter_if.sv
// Bus bundle between the data memory arbiter, its two requesters and the single-port memory.
// slave is the arbiter's view; master is the requester/memory side.
interface data_mem_arbiter_if #(
  parameter int unsigned BANK_W   = 2,
  parameter int unsigned OFFSET_W = 8,
  parameter int unsigned DATA_W   = 8
);
  logic                         cpu_req;
  logic                         cpu_we;
  logic [BANK_W-1:0]            cpu_bank;
  logic [OFFSET_W-1:0]          cpu_offset;
  logic [DATA_W-1:0]            cpu_wdata;
  logic                         cpu_gnt;
  logic                         cpu_done;
  logic [DATA_W-1:0]            cpu_rdata;
  logic                         cpu_err;

  logic                         dbg_req;
  logic                         dbg_we;
  logic [BANK_W+OFFSET_W-1:0]   dbg_addr;
  logic [DATA_W-1:0]            dbg_wdata;
  logic                         dbg_gnt;
  logic                         dbg_done;
  logic [DATA_W-1:0]            dbg_rdata;

  logic [BANK_W+OFFSET_W-1:0]   mem_addr;
  logic [DATA_W-1:0]            mem_wdata;
  logic                         mem_we;
  logic                         mem_re;
  logic [DATA_W-1:0]            mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_bank, cpu_offset, cpu_wdata,
    output cpu_gnt, cpu_done, cpu_rdata, cpu_err,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output dbg_gnt, dbg_done, dbg_rdata,
    output mem_addr, mem_wdata, mem_we, mem_re,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_bank, cpu_offset, cpu_wdata,
    input  cpu_gnt, cpu_done, cpu_rdata, cpu_err,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  dbg_gnt, dbg_done, dbg_rdata,
    input  mem_addr, mem_wdata, mem_we, mem_re,
    output mem_rdata
  );
endinterface

// File: rtl/data_mem_arbiter.sv
// Two-requester (cpu / debug) arbiter for the single-port data memory: alternating fairness,
// IDLE -> ACCESS -> RESP per grant. Define MEM_ARB_WPROT_EN to block cpu writes to the top bank.
module data_mem_arbiter #(
  parameter int unsigned BANK_W   = 2,
  parameter int unsigned OFFSET_W = 8,
  parameter int unsigned DATA_W   = 8
) (
  input logic               clk,
  input logic               rst,
  data_mem_arbiter_if.slave bus
);
  localparam int unsigned ADDR_W = BANK_W + OFFSET_W;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              last_owner_q;  // 1 = dbg; also the owner of the access in flight
  logic              lat_we_q;
  logic [ADDR_W-1:0] lat_addr_q;
  logic [DATA_W-1:0] lat_wdata_q;
  logic              cpu_done_q, dbg_done_q;
  logic [DATA_W-1:0] cpu_rdata_q, dbg_rdata_q;
  logic              block_we;

  logic accept, pick_dbg, in_access, in_resp;

  assign in_access = (state_q == ACCESS);
  assign in_resp   = (state_q == RESP);
  assign accept    = (state_q == IDLE) && (bus.cpu_req || bus.dbg_req);
  // On a tie the requester that lost the previous arbitration wins.
  assign pick_dbg  = bus.dbg_req && (!bus.cpu_req || !last_owner_q);

  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE:    state_d = accept ? ACCESS : IDLE;
      ACCESS:  state_d = RESP;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_owner_q <= 1'b1;
      lat_we_q     <= 1'b0;
      lat_addr_q   <= '0;
      lat_wdata_q  <= '0;
      cpu_done_q   <= 1'b0;
      dbg_done_q   <= 1'b0;
      cpu_rdata_q  <= '0;
      dbg_rdata_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        last_owner_q <= pick_dbg;
        lat_we_q     <= pick_dbg ? bus.dbg_we : bus.cpu_we;
        lat_addr_q   <= pick_dbg ? bus.dbg_addr : {bus.cpu_bank, bus.cpu_offset};
        lat_wdata_q  <= pick_dbg ? bus.dbg_wdata : bus.cpu_wdata;
      end
      cpu_done_q <= in_resp && !last_owner_q;
      dbg_done_q <= in_resp && last_owner_q;
      if (in_resp && !lat_we_q && !last_owner_q) cpu_rdata_q <= bus.mem_rdata;
      if (in_resp && !lat_we_q && last_owner_q)  dbg_rdata_q <= bus.mem_rdata;
    end
  end

`ifdef MEM_ARB_WPROT_EN
  logic blocked_q, cpu_err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blocked_q <= 1'b0;
      cpu_err_q <= 1'b0;
    end else begin
      if (accept) blocked_q <= !pick_dbg && bus.cpu_we && (&bus.cpu_bank);
      cpu_err_q <= in_resp && blocked_q;
    end
  end

  assign block_we    = blocked_q;
  assign bus.cpu_err = cpu_err_q;
`else
  assign block_we    = 1'b0;
  assign bus.cpu_err = 1'b0;
`endif

  // Memory side and grants decode straight from the state register.
  always_comb begin
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_we    = 1'b0;
    bus.mem_re    = 1'b0;
    if (in_access) begin
      bus.mem_addr  = lat_addr_q;
      bus.mem_wdata = lat_wdata_q;
      bus.mem_we    = lat_we_q && !block_we;
      bus.mem_re    = !lat_we_q;
    end
  end

  assign bus.cpu_gnt   = in_access && !last_owner_q;
  assign bus.dbg_gnt   = in_access && last_owner_q;
  assign bus.cpu_done  = cpu_done_q;
  assign bus.dbg_done  = dbg_done_q;
  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.dbg_rdata = dbg_rdata_q;
endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench for data_mem_arbiter: directed vector table, corner sequences,
// then randomized traffic against a transaction-level model with its own memory image.
module tb_data_mem_arbiter;
`ifdef MEM_ARB_WPROT_EN
  localparam bit Wprot = 1'b1;
`else
  localparam bit Wprot = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  data_mem_arbiter_if bus ();
  data_mem_arbiter dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] init_val(input logic [9:0] a);
    return a[7:0] ^ 8'h23 ^ {6'd0, a[9:8]};
  endfunction

  // Synchronous-read memory attached to the DUT
  logic [7:0] mem [1024];
  bit         mem_wr [1024];
  always @(posedge clk) begin
    if (bus.mem_re)
      bus.mem_rdata <= mem_wr[bus.mem_addr] ? mem[bus.mem_addr] : init_val(bus.mem_addr);
    if (bus.mem_we) begin
      mem[bus.mem_addr]    <= bus.mem_wdata;
      mem_wr[bus.mem_addr] <= 1'b1;
    end
  end

  // Reference memory image kept by the model
  logic [7:0] ref_mem [1024];
  bit         ref_wr [1024];
  function automatic logic [7:0] ref_rd(input logic [9:0] a);
    return ref_wr[a] ? ref_mem[a] : init_val(a);
  endfunction
  task automatic ref_write(input logic [9:0] a, input logic [7:0] d);
    ref_mem[a] = d;
    ref_wr[a]  = 1'b1;
  endtask

  typedef struct {
    bit         dbg;
    bit         we;
    logic [9:0] addr;
    logic [7:0] wdata;
    bit         exp_we;
    bit         exp_err;
    logic [7:0] exp_rdata;
  } vec_t;

  vec_t       tbl [7];
  logic [7:0] exp_rd [2];

  task automatic quiet(input string nm);
    chk({nm, "_ctl"}, 32'({bus.cpu_gnt, bus.dbg_gnt, bus.cpu_done, bus.dbg_done, bus.cpu_err,
                           bus.mem_we, bus.mem_re}), 32'd0);
    chk({nm, "_bus"}, 32'({bus.mem_addr, bus.mem_wdata}), 32'd0);
  endtask

  task automatic run_rec(input int i);
    vec_t v = tbl[i];
    bit   d = v.dbg;
    if (d) begin
      bus.dbg_req = 1'b1; bus.dbg_we = v.we; bus.dbg_addr = v.addr; bus.dbg_wdata = v.wdata;
    end else begin
      bus.cpu_req = 1'b1; bus.cpu_we = v.we; {bus.cpu_bank, bus.cpu_offset} = v.addr;
      bus.cpu_wdata = v.wdata;
    end
    @(negedge clk);
    chk($sformatf("rec%0d_idle_gnt", i), 32'({bus.cpu_gnt, bus.dbg_gnt}), 32'd0);
    @(posedge clk); #1;
    // Inputs are only sampled at acceptance: scramble them now
    bus.cpu_req = 1'b0; bus.dbg_req = 1'b0;
    bus.cpu_we = ~v.we; bus.dbg_we = ~v.we;
    bus.cpu_offset = 8'($urandom); bus.dbg_addr = 10'($urandom);
    bus.cpu_wdata = 8'($urandom); bus.dbg_wdata = 8'($urandom);
    @(negedge clk);
    chk($sformatf("rec%0d_gnt", i), 32'({bus.cpu_gnt, bus.dbg_gnt}), d ? 32'd1 : 32'd2);
    chk($sformatf("rec%0d_addr", i), 32'(bus.mem_addr), 32'(v.addr));
    chk($sformatf("rec%0d_we", i), 32'(bus.mem_we), 32'(v.exp_we));
    chk($sformatf("rec%0d_re", i), 32'(bus.mem_re), 32'(!v.we));
    if (v.we) chk($sformatf("rec%0d_wdata", i), 32'(bus.mem_wdata), 32'(v.wdata));
    @(posedge clk); #1;
    @(negedge clk);
    chk($sformatf("rec%0d_resp", i),
        32'({bus.mem_we, bus.mem_re, bus.cpu_gnt, bus.dbg_gnt, bus.cpu_done, bus.dbg_done}), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    if (!v.we) exp_rd[d] = v.exp_rdata;
    chk($sformatf("rec%0d_done", i), 32'({bus.cpu_done, bus.dbg_done}), d ? 32'd1 : 32'd2);
    chk($sformatf("rec%0d_err", i), 32'(bus.cpu_err), 32'(v.exp_err));
    chk($sformatf("rec%0d_cpu_rdata", i), 32'(bus.cpu_rdata), 32'(exp_rd[0]));
    chk($sformatf("rec%0d_dbg_rdata", i), 32'(bus.dbg_rdata), 32'(exp_rd[1]));
    if (v.we && v.exp_we) ref_write(v.addr, v.wdata);
    @(posedge clk); #1;
  endtask

  // Random-phase model state
  bit         pend [2], busy [2], f_we [2];
  logic [9:0] f_addr [2];
  logic [7:0] f_wd [2];
  int         acc_cyc, free_cyc;
  bit         acc_who, acc_we, acc_blk, last, in_acc, dn, w;
  logic [9:0] acc_addr;
  logic [7:0] acc_wd, acc_rd;

  initial begin
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_bank = '0; bus.cpu_offset = '0;
    bus.cpu_wdata = '0; bus.dbg_req = 1'b0; bus.dbg_we = 1'b0; bus.dbg_addr = '0;
    bus.dbg_wdata = '0;
    exp_rd[0] = 8'h00; exp_rd[1] = 8'h00;
    for (int r = 0; r < 2; r++) begin
      pend[r] = 1'b0; busy[r] = 1'b0; f_we[r] = 1'b0; f_addr[r] = '0; f_wd[r] = '0;
    end

    tbl[0] = '{1'b0, 1'b1, 10'h2F0, 8'h5A, 1'b1, 1'b0, 8'h00};
    tbl[1] = '{1'b0, 1'b0, 10'h2F0, 8'h00, 1'b0, 1'b0, 8'h5A};
    tbl[2] = '{1'b1, 1'b0, 10'h010, 8'h00, 1'b0, 1'b0, 8'h33};
    tbl[3] = '{1'b0, 1'b1, 10'h300, 8'hA5, !Wprot, Wprot, 8'h00};
    tbl[4] = '{1'b1, 1'b1, 10'h3FF, 8'h77, 1'b1, 1'b0, 8'h00};
    tbl[5] = '{1'b0, 1'b0, 10'h300, 8'h00, 1'b0, 1'b0, Wprot ? 8'h20 : 8'hA5};
    tbl[6] = '{1'b1, 1'b0, 10'h3FF, 8'h00, 1'b0, 1'b0, 8'h77};

    repeat (2) @(posedge clk);
    @(negedge clk);
    quiet("por");
    chk("por_rdata", 32'({bus.cpu_rdata, bus.dbg_rdata}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 7; i++) run_rec(i);

    // Mid-cycle reset clears everything at once, both requests held for the fairness run
    @(negedge clk); #2;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; {bus.cpu_bank, bus.cpu_offset} = 10'h010;
    bus.dbg_req = 1'b1; bus.dbg_we = 1'b0; bus.dbg_addr = 10'h010;
    rst = 1'b1;
    #1;
    quiet("async_rst");
    chk("async_rst_rdata", 32'({bus.cpu_rdata, bus.dbg_rdata}), 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_rd[0] = 8'h00; exp_rd[1] = 8'h00;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      chk($sformatf("fair_c%0d", c), 32'({bus.cpu_gnt, bus.dbg_gnt}),
          32'({(c % 6) == 1, (c % 6) == 4}));
      @(posedge clk); #1;
    end
    bus.cpu_req = 1'b0; bus.dbg_req = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // Reset during the ACCESS cycle of a dbg write drops it without done
    bus.dbg_req = 1'b1; bus.dbg_we = 1'b1; bus.dbg_addr = 10'h155; bus.dbg_wdata = 8'hC3;
    @(posedge clk); #1;
    @(negedge clk);
    chk("abort_pre_gnt", 32'(bus.dbg_gnt), 32'd1);
    chk("abort_pre_we", 32'(bus.mem_we), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("abort_we_drop", 32'({bus.mem_we, bus.dbg_gnt}), 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("abort_no_done%0d", c), 32'(bus.dbg_done), 32'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (c == 1) bus.dbg_req = 1'b0;
      @(negedge clk);
      chk($sformatf("regrant_gnt%0d", c), 32'(bus.dbg_gnt), 32'(c == 1));
      chk($sformatf("regrant_we%0d", c), 32'(bus.mem_we), 32'(c == 1));
      chk($sformatf("regrant_done%0d", c), 32'(bus.dbg_done), 32'(c == 3));
      if (c == 1) chk("regrant_addr", 32'(bus.mem_addr), 32'h155);
      @(posedge clk); #1;
    end
    ref_write(10'h155, 8'hC3);

    // Randomized traffic against the transaction-level model
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_rd[0] = 8'h00; exp_rd[1] = 8'h00;
    last = 1'b1; free_cyc = 0; acc_cyc = -10;
    acc_who = 1'b0; acc_we = 1'b0; acc_blk = 1'b0; acc_addr = '0; acc_wd = '0; acc_rd = '0;
    for (int c = 0; c < 600; c++) begin
      for (int r = 0; r < 2; r++) begin
        if (!pend[r] && !busy[r] && $urandom_range(0, 1) == 1) begin
          pend[r]   = 1'b1;
          f_we[r]   = 1'($urandom);
          f_addr[r] = {2'($urandom), 6'd0, 2'($urandom)};
          f_wd[r]   = 8'($urandom);
        end
      end
      bus.cpu_req = pend[0]; bus.cpu_we = f_we[0]; {bus.cpu_bank, bus.cpu_offset} = f_addr[0];
      bus.cpu_wdata = f_wd[0];
      bus.dbg_req = pend[1]; bus.dbg_we = f_we[1]; bus.dbg_addr = f_addr[1];
      bus.dbg_wdata = f_wd[1];
      @(negedge clk);
      in_acc = (c == acc_cyc + 1);
      dn     = (c == acc_cyc + 3);
      if (dn && !acc_we) exp_rd[acc_who] = acc_rd;
      chk("rnd_gnt", 32'({bus.cpu_gnt, bus.dbg_gnt}),
          32'({in_acc && !acc_who, in_acc && acc_who}));
      chk("rnd_done", 32'({bus.cpu_done, bus.dbg_done, bus.cpu_err}),
          32'({dn && !acc_who, dn && acc_who, dn && acc_blk}));
      chk("rnd_mem_ctl", 32'({bus.mem_we, bus.mem_re}),
          32'({in_acc && acc_we && !acc_blk, in_acc && !acc_we}));
      chk("rnd_mem_bus", 32'({bus.mem_addr, bus.mem_wdata}),
          in_acc ? 32'({acc_addr, acc_wd}) : 32'd0);
      chk("rnd_rdata", 32'({bus.cpu_rdata, bus.dbg_rdata}), 32'({exp_rd[0], exp_rd[1]}));
      if (dn) busy[acc_who] = 1'b0;
      if (c >= free_cyc && (pend[0] || pend[1])) begin
        w        = (pend[0] && pend[1]) ? !last : pend[1];
        acc_cyc  = c;
        acc_who  = w;
        acc_we   = f_we[w];
        acc_addr = f_addr[w];
        acc_wd   = f_wd[w];
        acc_blk  = Wprot && !w && f_we[w] && (f_addr[w][9:8] == 2'b11);
        if (!acc_we) acc_rd = ref_rd(acc_addr);
        else if (!acc_blk) ref_write(acc_addr, acc_wd);
        pend[w]  = 1'b0;
        busy[w]  = 1'b1;
        last     = w;
        free_cyc = c + 3;
      end
      @(posedge clk); #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Shares the single-port data memory between two requesters: the control unit and a debug/loader port. The control unit presents bank and offset separately: the 2-bit bank comes from the memory bank selector and the 8-bit offset comes from the bus. The debug port presents a flat address. The block arbitrates between the two with alternating fairness, sequences one memory access per grant, and returns read data and a completion pulse to the winning requester.

## Interface
- BANK_W, 2, bank select width (memory bank selector output)
- OFFSET_W, 8, in-bank offset width (bus width)
- DATA_W, 8, data word width
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- cpu_req  in  1  control unit access request
- cpu_we  in  1  1 = write, 0 = read
- cpu_bank  in  BANK_W  bank number
- cpu_offset  in  OFFSET_W  offset within bank
- cpu_wdata  in  DATA_W  write data
- cpu_gnt  out  1  request accepted (one-cycle pulse)
- cpu_done  out  1  access complete (one-cycle pulse)
- cpu_rdata  out  DATA_W  read data, held until next cpu read completes
- cpu_err  out  1  write rejected (pulses with cpu_done)
- dbg_req  in  1  debug access request
- dbg_we  in  1  1 = write, 0 = read
- dbg_addr  in  BANK_W+OFFSET_W  flat address
- dbg_wdata  in  DATA_W  write data
- dbg_gnt, dbg_done  out  1  as for cpu
- dbg_rdata  out  DATA_W  as for cpu
- mem_addr  out  BANK_W+OFFSET_W  memory address = {bank, offset}
- mem_wdata  out  DATA_W  memory write data
- mem_we  out  1  memory write enable
- mem_re  out  1  memory read enable
- mem_rdata  in  DATA_W  memory read data, valid the cycle after mem_re (synchronous read)

## Operation
- States:
  - IDLE: memory outputs are 0. On an edge with any req high, the winner's we/address/wdata are latched, and the state moves to ACCESS.
  - ACCESS: mem_addr/mem_wdata come from the latch. mem_we = latched we; mem_re = !latched we. The owner's gnt is high. Next state: RESP.
  - RESP: memory outputs are 0. On the exiting edge, a read loads the owner's rdata register from mem_rdata. The owner's done register is set. Next state: IDLE.
- Arbitration in IDLE:
  - A single requester wins.
  - When both request, the requester that did not win the previous arbitration wins (last_owner register).
- Requester rules:
  - req must be held until gnt.
  - Inputs are sampled only on the accepting edge; they may change after gnt.
  - req still high in the cycle after done is a new request.
- cpu address = {cpu_bank, cpu_offset}; dbg address = dbg_addr. No width conversion or wrap.
- The non-owner's gnt, done, err and rdata are unaffected by the other requester's access.
- Reset (async, any state):
  - state = IDLE; last_owner = dbg, so the cpu wins the first tie.
  - All gnt/done/err/mem_* outputs = 0; both rdata registers = 0.
  - An in-flight access is dropped with no done. The requester reissues.

## Timing
- With req high and the block in IDLE at edge N:
  - gnt high in cycle N+1 (ACCESS); mem_re/mem_we high in that cycle only.
  - done high, and rdata valid, in cycle N+3. The block is back in IDLE in that cycle, so arbitration of the next request overlaps done.
- Throughput: one access per 3 cycles; back-to-back accesses alternate when both requesters are held high.
- gnt, done and err are high for exactly one cycle each.
- mem_* outputs decode from the state register, so they drop immediately on rst.

## Configuration
- MEM_ARB_WPROT_EN defined:
  - cpu writes to the highest bank (cpu_bank = all ones) are blocked: granted and sequenced normally, but mem_we stays 0 in ACCESS.
  - cpu_err pulses together with cpu_done.
  - dbg writes are never blocked.
- MEM_ARB_WPROT_EN undefined: all writes proceed; cpu_err is tied 0.

## Test plan
- Reset: assert rst mid-cycle -> all outputs 0 immediately; cpu_rdata = dbg_rdata = 0.
- cpu write, bank 2, offset 0xF0, data 0x5A, req at edge N -> cycle N+1: cpu_gnt=1, mem_addr=0x2F0, mem_wdata=0x5A, mem_we=1; cycle N+3: cpu_done=1, cpu_err=0.
- cpu read of 0x2F0 with memory model holding 0x5A -> mem_re=1 in N+1; cpu_rdata=0x5A with cpu_done in N+3, held afterwards while a dbg read of 0x010 returns 0x33 on dbg_rdata only.
- cpu_req and dbg_req both held high from reset -> grant order cpu, dbg, cpu, dbg, with gnt pulses 3 cycles apart.
- rst asserted during ACCESS of a dbg write -> mem_we falls in the same cycle; dbg_done never pulses; after release, the dbg request is re-granted in the normal 3-cycle sequence.
- cpu write, bank 3, offset 0x00 -> with MEM_ARB_WPROT_EN: mem_we stays 0, cpu_err=1 and cpu_done=1 in N+3. Without the macro: mem_we=1 in N+1, cpu_err=0.
